// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit: funct3 op codes,
// FSM state encoding and operand-signedness helpers.
package mdu_seq_pkg;

    localparam logic [2:0] MDUOp_MUL    = 3'b000;
    localparam logic [2:0] MDUOp_MULH   = 3'b001;
    localparam logic [2:0] MDUOp_MULHSU = 3'b010;
    localparam logic [2:0] MDUOp_MULHU  = 3'b011;
    localparam logic [2:0] MDUOp_DIV    = 3'b100;
    localparam logic [2:0] MDUOp_DIVU   = 3'b101;
    localparam logic [2:0] MDUOp_REM    = 3'b110;
    localparam logic [2:0] MDUOp_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == MDUOp_MUL) || (op == MDUOp_MULH) || (op == MDUOp_MULHSU) ||
               (op == MDUOp_DIV) || (op == MDUOp_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == MDUOp_MUL) || (op == MDUOp_MULH) ||
               (op == MDUOp_DIV) || (op == MDUOp_REM);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration: multiply add-then-shift-right, or restoring
// divide shift-left-then-trial-subtract, on a {hi, lo} register pair.
module md_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_nx,
    output logic [XLEN-1:0] lo_nx
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            // A non-negative trial difference means the divisor fits: quotient bit 1.
            if (!diff[XLEN]) begin
                hi_nx = diff[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = shifted[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: magnitudes are iterated one bit per
// cycle, then sign-corrected and the requested word selected.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_e state, state_nx;

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              sa, sb;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient, remainder;

    logic              accept;
    logic              sa_in, sb_in;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_res;

    logic              step_div;
    logic [XLEN-1:0]   step_hi, step_lo, step_opnd;
    logic [XLEN-1:0]   hi_nx, lo_nx;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        accept   = (state == ST_IDLE) && start && !flush;
        sa_in    = a_is_signed(op) && A[XLEN-1];
        sb_in    = b_is_signed(op) && B[XLEN-1];
        a_mag_in = sa_in ? -A : A;
        b_mag_in = sb_in ? -B : B;
        div_zero = op_is_div(op) && (B == '0);
        div_ovf  = ((op == MDUOp_DIV) || (op == MDUOp_REM)) &&
                   (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        fast     = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU.
        if (div_zero)
            fast_res = op[1] ? A : '1;
        else
            fast_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_comb begin
        step_div  = op_is_div(op_q);
        step_hi   = step_div ? remainder : product[2*XLEN-1:XLEN];
        step_lo   = step_div ? quotient  : product[XLEN-1:0];
        step_opnd = step_div ? b_mag     : a_mag;
    end

    md_iter_step #(.XLEN(XLEN)) u_step (
        .is_div  (step_div),
        .hi      (step_hi),
        .lo      (step_lo),
        .operand (step_opnd),
        .hi_nx   (hi_nx),
        .lo_nx   (lo_nx)
    );

    always_comb begin
        prod_fix = (sa ^ sb) ? -product : product;
        unique case (op_q)
            MDUOp_MUL:                             fix_res = prod_fix[XLEN-1:0];
            MDUOp_MULH, MDUOp_MULHSU, MDUOp_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MDUOp_DIV,  MDUOp_DIVU:                fix_res = (sa ^ sb) ? -quotient : quotient;
            default:                               fix_res = sa ? -remainder : remainder;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = fast ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush)            state_nx = ST_IDLE;
                else if (cnt == '0)   state_nx = ST_FIX;
            end
            ST_FIX:  state_nx = flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        stall = 1'b0;
        done  = 1'b0;
        if (!rst) begin
            busy = (state != ST_IDLE);
            unique case (state)
                ST_IDLE: stall = start && !flush;
                ST_CALC: stall = 1'b1;
                ST_FIX:  stall = 1'b1;
                ST_DONE: done  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            op_q  <= op;
            a_mag <= a_mag_in;
            b_mag <= b_mag_in;
            sa    <= sa_in;
            sb    <= sb_in;
        end
    end

    // Multiply keeps the multiplier in product[lo]; divide shifts the dividend out of quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            product   <= '0;
            quotient  <= '0;
            remainder <= '0;
            result    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (accept) begin
                    cnt       <= CNT_W'(31);
                    product   <= {{XLEN{1'b0}}, b_mag_in};
                    quotient  <= a_mag_in;
                    remainder <= '0;
                    if (fast) result <= fast_res;
                end
                ST_CALC: if (!flush) begin
                    cnt <= cnt - 1'b1;
                    if (step_div) begin
                        remainder <= hi_nx;
                        quotient  <= lo_nx;
                    end else begin
                        product   <= {hi_nx, lo_nx};
                    end
                end
                ST_FIX:  if (!flush) result <= fix_res;
                ST_DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: a cycle-level behavioural model checked every cycle,
// directed RV32M cases with literal expectations, then randomized traffic.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mdu_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Model: m_rem counts cycles left until the done cycle of the active op.
    bit          model_ready = 0;
    bit          m_active = 0;
    int          m_rem = 0;
    logic [31:0] m_res = 0;
    logic [31:0] m_res_out = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active  = 0;
            m_res_out = 0;
        end else if (flush) begin
            m_active = 0;
        end else if (!m_active) begin
            if (start) begin
                m_res    = ref_result(op, A, B);
                m_rem    = ref_latency(op, A, B) - 1;
                m_active = 1;
                if (m_rem == 0) m_res_out = m_res;
            end
        end else if (m_rem == 0) begin
            m_active = 0;
        end else begin
            m_rem--;
            if (m_rem == 0) m_res_out = m_res;
        end
        model_ready = 1;
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("done",   64'(done),  64'(!rst && m_active && m_rem == 0));
            chk("busy",   64'(busy),  64'(!rst && m_active));
            chk("stall",  64'(stall),
                64'(rst ? 1'b0 : (!m_active ? (start && !flush) : (m_rem != 0))));
            chk("result", 64'(result), 64'(m_res_out));
        end
    end

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int c;
        @(posedge clk); #1;
        start = 1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 0;
        c = 1;
        while (c < 60) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
            c++;
        end
        if (c >= 60) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, c);
        end else begin
            chk({name, "_latency"}, 64'(c), 64'(exp_lat));
            chk({name, "_result"}, 64'(result), 64'(exp_res));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1; start = 0; flush = 0; op = 0; A = 0; B = 0;

        chk("model_mul",    64'(ref_result(3'd0, 32'd7, 32'hFFFF_FFFD)), 64'h0000_0000_FFFF_FFEB);
        chk("model_mulhu",  64'(ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'h0000_0000_FFFF_FFFE);
        chk("model_mulhsu", 64'(ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'h0000_0000_FFFF_FFFF);
        chk("model_rem",    64'(ref_result(3'd6, 32'hFFFF_FFF9, 32'd2)), 64'h0000_0000_FFFF_FFFF);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_busy",   64'(busy),   64'd0);
        chk("reset_done",   64'(done),   64'd0);
        chk("reset_stall",  64'(stall),  64'd0);
        chk("reset_result", 64'(result), 64'd0);

        do_op("mul",   3'd0, 32'd7,          32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
        do_op("mulh",  3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'h0000_0000);
        do_op("div",   3'd4, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFD);
        do_op("rem",   3'd6, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFF);
        do_op("divu0", 3'd5, 32'd5,          32'd0,         1,  32'hFFFF_FFFF);
        do_op("rem0",  3'd6, 32'hFFFF_FFF9,  32'd0,         1,  32'hFFFF_FFF9);
        do_op("divov", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000);
        do_op("remov", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h0000_0000);
        do_op("divu",  3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 34, 32'h0000_0000);

        // Flush a DIV in cycle 10, restart in cycle 12.
        @(posedge clk); #1;
        start = 1; op = 3'd4; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        chk("flush_busy",   64'(busy),   64'd0);
        chk("flush_stall",  64'(stall),  64'd0);
        chk("flush_done",   64'(done),   64'd0);
        chk("flush_result", 64'(result), 64'h0000_0000);
        do_op("after_flush", 3'd4, 32'd100, 32'd7, 34, 32'd14);

        // Reset a MUL in cycle 20.
        @(posedge clk); #1;
        start = 1; op = 3'd0; A = 32'd1234; B = 32'd5678;
        @(posedge clk); #1;
        start = 0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_result", 64'(result), 64'd0);

        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            A     = pick();
            B     = pick();
            flush = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk); #1;
        start = 0; flush = 0; rst = 0;
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
